beam_trigger_scaler: RTL and testbench



---
 rtl/beam_trigger_scaler_pkg.sv | 17 +
 rtl/beam_rate_counter.sv | 54 +++++
 rtl/beam_trigger_scaler.sv | 150 +++++++++++++++
 tb/tb_beam_trigger_scaler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_trigger_scaler_pkg.sv
// Shared types and status-word layout for the beam trigger rate scaler.
// Pure declarations: no latency, no flow control.
package trigger_scaler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PUBLISH = 2'd2
  } scaler_state_t;

  localparam int DATA_W           = 32;
  localparam int SAT_BIT          = 31;
  localparam int STATUS_SEQ_LSB   = 24;
  localparam int STATUS_STATE_LSB = 22;
  localparam int STATUS_EN_BIT    = 21;

endpackage

// File: rtl/beam_rate_counter.sv
// One beam: rising-edge detect, dead-time holdoff, saturating gated count.
// Counts in the cycle the edge is seen; no backpressure, always accepts.
module beam_rate_counter #(
  parameter int COUNT_BITS   = 24,
  parameter int HOLDOFF_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trigger,
  input  logic                    count_en,
  input  logic                    restart,
  input  logic                    restart_with_edge,
  input  logic [HOLDOFF_BITS-1:0] holdoff,
  output logic [COUNT_BITS-1:0]   count,
  output logic                    sat
);

  logic                    trigger_q;
  logic [HOLDOFF_BITS-1:0] hold_cnt;
  logic                    counted;

  assign counted = trigger & ~trigger_q & count_en & (hold_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      trigger_q <= 1'b0;
      hold_cnt  <= '0;
      count     <= '0;
      sat       <= 1'b0;
    end else begin
      trigger_q <= trigger;

      // Edges seen while blind are dropped outright, never queued.
      if (counted)
        hold_cnt <= holdoff;
      else if (hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;

      if (restart) begin
        count <= '0;
        sat   <= 1'b0;
      end else if (restart_with_edge) begin
        count <= COUNT_BITS'(counted);
        sat   <= 1'b0;
      end else if (counted) begin
        if (&count)
          sat <= 1'b1;
        else
          count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/beam_trigger_scaler.sv
// Gated per-beam trigger scaler with double-buffered snapshot and registered read port.
// Read data one cycle after rd_req_i; no backpressure, a request may be issued every cycle.
module beam_trigger_scaler
  import trigger_scaler_pkg::*;
#(
  parameter int NBEAMS       = 2,
  parameter int COUNT_BITS   = 24,
  parameter int GATE_BITS    = 32,
  parameter int HOLDOFF_BITS = 8,
  parameter int ADDR_BITS    = 7
) (
  input  logic                    aclk,
  input  logic                    reset_i,
  input  logic [NBEAMS-1:0]       trigger_i,
  input  logic [NBEAMS-1:0]       beam_mask_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [GATE_BITS-1:0]    gate_period_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic                    rd_req_i,
  input  logic [ADDR_BITS-1:0]    rd_addr_i,
  output logic                    rd_valid_o,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic                    period_done_o,
  output logic [7:0]              snapshot_seq_o
);

  scaler_state_t          state, state_nxt;
  logic [GATE_BITS-1:0]   gate_cnt, gate_nxt;
  logic                   publish;
  logic                   counting;
  logic                   restart;
  logic                   restart_with_edge;
  logic [COUNT_BITS-1:0]  acc_cnt  [NBEAMS];
  logic [NBEAMS-1:0]      acc_sat;
  logic [COUNT_BITS-1:0]  snap_cnt [NBEAMS];
  logic [NBEAMS-1:0]      snap_sat;
  logic [DATA_W-1:0]      rd_word;

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      state    <= IDLE;
      gate_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gate_nxt  = gate_cnt;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_nxt = RUN;
          gate_nxt  = gate_period_i;
        end
      end
      RUN: begin
        if (!enable_i)
          state_nxt = IDLE;
        else if (clear_i)
          gate_nxt = gate_period_i;
        else if (gate_cnt == '0)
          state_nxt = PUBLISH;
        else
          gate_nxt = gate_cnt - 1'b1;
      end
      PUBLISH: begin
        publish   = !clear_i;
        state_nxt = enable_i ? RUN : IDLE;
        gate_nxt  = gate_period_i;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear_i)
      gate_nxt = gate_period_i;
  end

  // Accumulators sit at zero whenever no gate is open; PUBLISH keeps its own edge.
  assign counting          = (state == RUN) || (state == PUBLISH);
  assign restart           = clear_i || (state == IDLE) || ((state == RUN) && !enable_i);
  assign restart_with_edge = (state == PUBLISH);

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    beam_rate_counter #(
      .COUNT_BITS   (COUNT_BITS),
      .HOLDOFF_BITS (HOLDOFF_BITS)
    ) u_beam (
      .clk               (aclk),
      .reset             (reset_i),
      .trigger           (trigger_i[b]),
      .count_en          (counting && beam_mask_i[b]),
      .restart           (restart),
      .restart_with_edge (restart_with_edge),
      .holdoff           (holdoff_i),
      .count             (acc_cnt[b]),
      .sat               (acc_sat[b])
    );
  end

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      for (int b = 0; b < NBEAMS; b++)
        snap_cnt[b] <= '0;
      snap_sat       <= '0;
      snapshot_seq_o <= '0;
      period_done_o  <= 1'b0;
    end else begin
      period_done_o <= publish;
      if (publish) begin
        for (int b = 0; b < NBEAMS; b++)
          snap_cnt[b] <= acc_cnt[b];
        snap_sat       <= acc_sat;
        snapshot_seq_o <= snapshot_seq_o + 8'd1;
      end
    end
  end

  // Reads sample the bank before any same-cycle publish lands.
  always_comb begin
    rd_word = '0;
    if (rd_addr_i == ADDR_BITS'(NBEAMS)) begin
      rd_word[STATUS_SEQ_LSB +: 8]   = snapshot_seq_o;
      rd_word[STATUS_STATE_LSB +: 2] = state;
      rd_word[STATUS_EN_BIT]         = enable_i;
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (rd_addr_i == ADDR_BITS'(b)) begin
          rd_word[COUNT_BITS-1:0] = snap_cnt[b];
          rd_word[SAT_BIT]        = snap_sat[b];
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i)
        rd_data_o <= rd_word;
    end
  end

endmodule

// File: tb/tb_beam_trigger_scaler.sv
// Randomized and directed bench for beam_trigger_scaler with a queue-based scoreboard.
module tb_beam_trigger_scaler;

  localparam int NB   = 2;
  localparam int CB   = 5;
  localparam int GB   = 32;
  localparam int HB   = 8;
  localparam int AB   = 7;
  localparam int MAXC = (1 << CB) - 1;

  logic          aclk = 1'b0;
  logic          reset_i;
  logic [NB-1:0] trigger_i;
  logic [NB-1:0] beam_mask_i;
  logic          enable_i;
  logic          clear_i;
  logic [GB-1:0] gate_period_i;
  logic [HB-1:0] holdoff_i;
  logic          rd_req_i;
  logic [AB-1:0] rd_addr_i;
  logic          rd_valid_o;
  logic [31:0]   rd_data_o;
  logic          period_done_o;
  logic [7:0]    snapshot_seq_o;

  always #5 aclk = ~aclk;

  beam_trigger_scaler #(
    .NBEAMS(NB), .COUNT_BITS(CB), .GATE_BITS(GB), .HOLDOFF_BITS(HB), .ADDR_BITS(AB)
  ) dut (
    .aclk(aclk), .reset_i(reset_i), .trigger_i(trigger_i), .beam_mask_i(beam_mask_i),
    .enable_i(enable_i), .clear_i(clear_i), .gate_period_i(gate_period_i),
    .holdoff_i(holdoff_i), .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .period_done_o(period_done_o),
    .snapshot_seq_o(snapshot_seq_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [31:0] rd_q[$];
  int          pd_cyc_q[$];
  int          pd_seq_q[$];

  // Reference model: state 0/1/2 = idle/run/publish, plain integer counts.
  int m_st, m_left, m_seq;
  int m_acc[NB], m_hold[NB], m_snap[NB];
  bit m_sat[NB], m_prev[NB], m_snap_sat[NB];
  bit m_pub_flag;

  function automatic logic [31:0] exp_read(int a);
    logic [31:0] v = '0;
    if (a < NB) begin
      v = 32'(m_snap[a]);
      v[31] = m_snap_sat[a];
    end else if (a == NB) begin
      v[31:24] = 8'(m_seq);
      v[23:22] = 2'(m_st);
      v[21]    = enable_i;
    end
    return v;
  endfunction

  task automatic model_edge();
    bit cnt[NB];
    bit open_gate, pub, zap;
    open_gate  = (m_st == 1) || (m_st == 2);
    pub        = (m_st == 2) && !clear_i;
    zap        = clear_i || (m_st == 0) || (m_st == 1 && !enable_i);
    m_pub_flag = 1'b0;
    if (reset_i) begin
      m_st = 0; m_left = 0; m_seq = 0;
      for (int b = 0; b < NB; b++) begin
        m_acc[b] = 0; m_hold[b] = 0; m_snap[b] = 0;
        m_sat[b] = 0; m_prev[b] = 0; m_snap_sat[b] = 0;
      end
      return;
    end
    for (int b = 0; b < NB; b++)
      cnt[b] = trigger_i[b] && !m_prev[b] && open_gate && beam_mask_i[b] && (m_hold[b] == 0);
    if (pub) begin
      for (int b = 0; b < NB; b++) begin
        m_snap[b]     = m_acc[b];
        m_snap_sat[b] = m_sat[b];
      end
      m_seq = (m_seq + 1) % 256;
      pd_cyc_q.push_back(cyc + 1);
      pd_seq_q.push_back(m_seq);
      m_pub_flag = 1'b1;
    end
    for (int b = 0; b < NB; b++) begin
      if (cnt[b]) m_hold[b] = int'(holdoff_i);
      else if (m_hold[b] > 0) m_hold[b]--;
      if (zap) begin
        m_acc[b] = 0; m_sat[b] = 0;
      end else if (m_st == 2) begin
        m_acc[b] = cnt[b] ? 1 : 0; m_sat[b] = 0;
      end else if (cnt[b]) begin
        if (m_acc[b] == MAXC) m_sat[b] = 1;
        else m_acc[b]++;
      end
      m_prev[b] = trigger_i[b];
    end
    case (m_st)
      0: if (enable_i) begin m_st = 1; m_left = int'(gate_period_i); end
      1: begin
        if (!enable_i) m_st = 0;
        else if (clear_i) m_left = int'(gate_period_i);
        else if (m_left == 0) m_st = 2;
        else m_left--;
      end
      default: begin
        m_st = enable_i ? 1 : 0;
        m_left = int'(gate_period_i);
      end
    endcase
  endtask

  task automatic step();
    if (rd_req_i && !reset_i) rd_q.push_back(exp_read(int'(rd_addr_i)));
    model_edge();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (rd_valid_o) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got data %h with no request pending", rd_data_o);
      end else begin
        logic [31:0] e;
        e = rd_q.pop_front();
        if (rd_data_o !== e) begin
          errors++;
          $display("FAIL rd_data at cycle %0d got %h want %h", cyc, rd_data_o, e);
        end
      end
    end
    if (period_done_o) begin
      checks++;
      if (pd_cyc_q.size() == 0) begin
        errors++;
        $display("FAIL period_done unexpected at cycle %0d seq %0d", cyc, snapshot_seq_o);
      end else begin
        int ec, es;
        ec = pd_cyc_q.pop_front();
        es = pd_seq_q.pop_front();
        if (ec != cyc || int'(snapshot_seq_o) != es) begin
          errors++;
          $display("FAIL period_done got cycle %0d seq %0d want cycle %0d seq %0d",
                   cyc, snapshot_seq_o, ec, es);
        end
      end
    end else if (pd_cyc_q.size() > 0 && pd_cyc_q[0] <= cyc) begin
      checks++;
      errors++;
      $display("FAIL period_done missing got 0 want pulse at cycle %0d", pd_cyc_q[0]);
      void'(pd_cyc_q.pop_front());
      void'(pd_seq_q.pop_front());
    end
  end

  function automatic bit pat(int mode, int i);
    case (mode)
      0:       return 1'b0;
      1:       return ((i / 2) % 2) == 1;
      2:       return (i % 2) == 1;
      3:       return (i == 10) || (i == 20) || (i == 30);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_until_pub(int m0, int m1, int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      trigger_i = {pat(m1, i), pat(m0, i)};
      step();
      done = m_pub_flag;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL gate_timeout got no publish within %0d cycles want publish", bound);
    end
  endtask

  task automatic wait_last_run(int m0, int bound);
    for (int i = 0; i < bound; i++) begin
      if (m_st == 1 && m_left == 0) return;
      trigger_i = {1'b0, pat(m0, i)};
      step();
    end
    checks++;
    errors++;
    $display("FAIL last_run_timeout got none within %0d cycles want gate end", bound);
  endtask

  task automatic reads(int a0, int a1, int a2);
    int a[3];
    a = '{a0, a1, a2};
    for (int i = 0; i < 3; i++) begin
      if (a[i] >= 0) begin
        rd_req_i  = 1'b1;
        rd_addr_i = AB'(a[i]);
        step();
      end
    end
    rd_req_i = 1'b0;
    step();
  endtask

  task automatic stop_gate();
    enable_i  = 1'b0;
    trigger_i = '0;
    step();
  endtask

  initial begin
    reset_i = 1'b1; trigger_i = '0; beam_mask_i = '1; enable_i = 1'b0; clear_i = 1'b0;
    gate_period_i = 32'd99; holdoff_i = '0; rd_req_i = 1'b0; rd_addr_i = '0;
    repeat (3) step();
    reset_i = 1'b0;
    chk("reset_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("reset_rd_data", rd_data_o, 32'd0);
    chk("reset_period_done", 32'(period_done_o), 32'd0);
    chk("reset_seq", 32'(snapshot_seq_o), 32'd0);
    reads(0, 1, 2);

    // Basic gate: beam0 edge every 4 cycles, beam1 idle.
    enable_i = 1'b1;
    run_until_pub(1, 0, 400);
    stop_gate();
    reads(0, 1, 2);

    // Holdoff drops edges during dead time.
    holdoff_i = 8'd10; enable_i = 1'b1;
    run_until_pub(1, 0, 400);
    stop_gate();
    reads(0, -1, -1);

    // Saturation, then a clean gate with 3 edges.
    holdoff_i = '0; enable_i = 1'b1;
    run_until_pub(2, 0, 400);
    run_until_pub(3, 0, 400);
    stop_gate();
    reads(0, 2, -1);

    // Clear coincident with gate expiry.
    gate_period_i = 32'd20; enable_i = 1'b1;
    wait_last_run(1, 100);
    clear_i = 1'b1; step(); clear_i = 1'b0;
    reads(0, 2, -1);
    run_until_pub(1, 1, 200);
    stop_gate();
    reads(0, 1, 2);

    // Edge and read in the publish cycle.
    gate_period_i = 32'd15; enable_i = 1'b1;
    wait_last_run(0, 100);
    trigger_i = '0; step();
    trigger_i = 2'b01; rd_req_i = 1'b1; rd_addr_i = '0; step();
    rd_req_i = 1'b0;
    run_until_pub(0, 0, 100);
    stop_gate();
    reads(0, -1, -1);

    // Masked beam, status and out-of-range reads, enable drop, reset mid-gate.
    beam_mask_i = 2'b01; gate_period_i = 32'd30; enable_i = 1'b1;
    run_until_pub(1, 1, 200);
    stop_gate();
    reads(1, 2, 5);
    beam_mask_i = 2'b11; enable_i = 1'b1;
    for (int i = 0; i < 10; i++) begin trigger_i = {pat(1, i), pat(1, i)}; step(); end
    reads(2, -1, -1);
    stop_gate();
    reads(2, 0, -1);
    enable_i = 1'b1;
    for (int i = 0; i < 8; i++) begin trigger_i = {pat(2, i), pat(2, i)}; step(); end
    reset_i = 1'b1; step(); reset_i = 1'b0;
    reads(0, 1, 2);

    // Random traffic.
    enable_i = 1'b1; holdoff_i = 8'd2;
    for (int i = 0; i < 3000; i++) begin
      int r;
      trigger_i = NB'($urandom);
      if ($urandom_range(0, 99) < 3) beam_mask_i = NB'($urandom);
      clear_i = ($urandom_range(0, 99) < 2);
      r = $urandom_range(0, 99);
      if (enable_i && r < 1) enable_i = 1'b0;
      else if (!enable_i && r < 10) enable_i = 1'b1;
      gate_period_i = 32'($urandom_range(2, 25));
      if ($urandom_range(0, 99) < 5) holdoff_i = 8'($urandom_range(0, 4));
      rd_req_i  = ($urandom_range(0, 99) < 40);
      rd_addr_i = AB'($urandom_range(0, 5));
      step();
    end
    clear_i = 1'b0; rd_req_i = 1'b0;
    repeat (5) step();
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("pd_queue_drained", 32'(pd_cyc_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
